instr_issue_queue: RTL and testbench
====================================

Name: instr_issue_queue

Overview:
- Front end that sits directly upstream of the Tomasulo core and drives its `instr` input.
- Fetches words from an instruction memory with 1-cycle read latency and buffers them in a small FIFO.
- Presents one instruction per cycle in a register that holds while the core's reservation-station stall for that instruction's class is asserted.
- Detects end of program (word 32'h0), then drains the FIFO and reports done.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- PC_RESET, 32'h0000_0000, first fetch address
- BUBBLE, 32'h0000_0000, word driven when no instruction is presented (decodes to no enable)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- fetch_en  in  1  level; while high (and not halted) fetching may proceed
- imem_rd_en  out  1  read request this cycle
- imem_addr  out  32  word-aligned read address
- imem_rdata  in  32  read data, valid exactly 1 cycle after imem_rd_en
- A_stall  in  1  add/mul RS full; currently presented instr not accepted
- LS_stall  in  1  load/store RS full; currently presented instr not accepted
- instr  out  32  registered instruction to the core
- done  out  1  halted, FIFO empty, instr == BUBBLE
- issued_cnt  out  16  instructions accepted by the core, saturating at 16'hFFFF

Behaviour:
- Reset (reset==0 at an edge) overrides everything, including mid-operation:
  - pc=PC_RESET, FIFO empty, inflight=0, halted=0.
  - instr=BUBBLE, imem_rd_en=0, done=0, issued_cnt=0.
- States: RUN (fetching allowed), HALT (end marker seen). RUN→HALT when a returning word equals 32'h0. HALT exits only by reset.
- Fetch request: imem_rd_en = RUN & fetch_en & (count + inflight < DEPTH).
  - On a request: imem_addr=pc; pc ← pc+4 (wraps at 2^32); inflight ← 1 next cycle.
  - Back-to-back requests are allowed when credit permits.
- Response: when inflight==1, imem_rdata is sampled.
  - Nonzero word in RUN → push at tail.
  - Word 32'h0 → not pushed; state→HALT.
  - Any response arriving in HALT (the request issued the same cycle the marker returned) is discarded.
- Class of held instr, by opcode [6:0]:
  - 0000011 / 0100011 → LS class; blocked by LS_stall.
  - 0110011 / 0010011 → A class; blocked by A_stall.
  - Any other opcode, or BUBBLE → never blocked; consumed in one cycle.
- Advance rule at each edge:
  - If instr is not blocked: instr ← FIFO head, with pop, if non-empty; else instr ← BUBBLE.
  - If blocked: instr holds and the FIFO does not pop.
- issued_cnt increments on each edge where a non-BUBBLE instr of class LS or A is not blocked; saturates.
- Simultaneous push and pop: legal at any occupancy, including full (pop frees a slot in the same edge) and empty. If the FIFO is empty and a response arrives while instr advances, the new word goes to the FIFO, not directly to instr; one cycle of bypass latency is accepted.
- Full: credit rule guarantees no overflow; an overflow assertion fires if a push occurs with count==DEPTH and no pop.
- Pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.
- Stall inputs are sampled only against the registered instr, so there is no combinational path from A_stall/LS_stall to instr.
- fetch_en low: no new requests; an in-flight response is still accepted; issue continues.
- done = HALT & count==0 & inflight==0 & instr==BUBBLE; registered, asserted the cycle after the condition holds.

Decomposition:
- Shared package holds:
  - opcode constants OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM
  - enum issue_class_t {CLS_NONE, CLS_A, CLS_LS}
  - the classify function
  - BUBBLE default
- One natural sub-module: instr_fifo (DEPTH x 32, push/pop/count/full/empty), distinct from the existing tag FIFO.

Test Plan:
- Memory holds addi, add, lw, sw, 0 at 0x0–0x10; no stalls → instr shows the four words on consecutive cycles starting 3 cycles after reset release; then BUBBLE; done=1; issued_cnt=4; no imem request beyond addr 0x14.
- Stream of adds with A_stall held high 5 cycles → instr holds the same add for 5 cycles; FIFO fills to 4; imem_rd_en drops when count+inflight==4; resumes the cycle after A_stall falls.
- lw presented with LS_stall=1 and A_stall=0 → held. add presented with LS_stall=1 → accepted next edge.
- fetch_en toggled low for 3 cycles → no requests; issue drains buffered entries; pc continues from the next address after re-enable with no duplicate or missed words.
- Reset asserted low for one cycle mid-stream with FIFO at 3 entries → next cycle instr=BUBBLE, issued_cnt=0, first request at PC_RESET.
- Unknown opcode 0x0000007F in the stream → consumed in 1 cycle even with both stalls high; not counted in issued_cnt.

Source files
------------

// File: rtl/instr_issue_queue_pkg.sv
// Shared opcode constants, issue classes and the classifier used by the issue queue.
package instr_issue_queue_pkg;

  localparam logic [6:0]  OPC_LOAD       = 7'b0000011;
  localparam logic [6:0]  OPC_STORE      = 7'b0100011;
  localparam logic [6:0]  OPC_OP         = 7'b0110011;
  localparam logic [6:0]  OPC_OPIMM      = 7'b0010011;
  localparam logic [31:0] BUBBLE_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] END_MARKER     = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_A    = 2'd1,
    CLS_LS   = 2'd2
  } issue_class_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic issue_class_t classify(input logic [6:0] opcode);
    issue_class_t cls;
    case (opcode)
      OPC_LOAD, OPC_STORE: cls = CLS_LS;
      OPC_OP, OPC_OPIMM:   cls = CLS_A;
      default:             cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_issue_queue_if.sv
// Fetch-side memory port and core-side issue port of the instruction issue queue.
interface instr_issue_queue_if;
  logic        fetch_en;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        A_stall;
  logic        LS_stall;
  logic [31:0] instr;
  logic        done;
  logic [15:0] issued_cnt;

  modport master (
    input  fetch_en, imem_rdata, A_stall, LS_stall,
    output imem_rd_en, imem_addr, instr, done, issued_cnt
  );

  modport slave (
    output fetch_en, imem_rdata, A_stall, LS_stall,
    input  imem_rd_en, imem_addr, instr, done, issued_cnt
  );
endinterface

// File: rtl/instr_issue_queue_chk.sv
// Protocol checker for the instruction FIFO: a push into a full FIFO must pair with a pop.
module instr_issue_queue_chk (
  input logic clk,
  input logic reset,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);

  overflow_a : assert property (@(posedge clk) disable iff (!reset)
    !(push_i && !pop_i && full_i));

endmodule

// File: rtl/instr_issue_queue_fifo.sv
// Circular DEPTH x W buffer with wrapping pointers; push and pop may coincide at any occupancy.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;

  // Storage, pointers and occupancy update
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH[PW:0]);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction fetch/issue front end: credit-limited fetch into a FIFO, one registered
// instruction per cycle toward the core, held while its reservation-station class stalls.
module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = BUBBLE_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  instr_issue_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   instr_q, instr_d;
  logic          done_q, done_d;
  logic [15:0]   issued_q, issued_d;

  logic [31:0]   fifo_head_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW:0]   credit_s;
  logic          req_s;
  logic          push_s;
  logic          pop_s;
  logic          blocked_s;
  logic          accept_s;
  logic          marker_s;
  issue_class_t  cls_s;

  // Occupancy plus the outstanding read must stay below DEPTH, so a push never overflows.
  // The request is also masked during reset so the memory sees no read while reset is low.
  assign credit_s = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q};
  assign req_s    = reset && (state_q == ST_RUN) && bus.fetch_en && (credit_s < DEPTH[CW:0]);

  // Response handling, issue advance, counters and next-state selection
  always_comb begin
    cls_s      = classify(instr_q[6:0]);
    blocked_s  = 1'b0;
    accept_s   = 1'b0;
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    issued_d   = issued_q;
    inflight_d = req_s;
    marker_s   = inflight_q && (state_q == ST_RUN) && (bus.imem_rdata == END_MARKER);
    push_s     = inflight_q && (state_q == ST_RUN) && (bus.imem_rdata != END_MARKER);

    if (instr_q == BUBBLE) begin
      blocked_s = 1'b0;
    end else begin
      blocked_s = ((cls_s == CLS_A) && bus.A_stall) || ((cls_s == CLS_LS) && bus.LS_stall);
    end
    pop_s    = !blocked_s && !fifo_empty_s;
    accept_s = !blocked_s && (instr_q != BUBBLE) && (cls_s != CLS_NONE);

    if (req_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    if (marker_s) begin
      state_d = ST_HALT;
    end else begin
      state_d = state_q;
    end

    if (blocked_s) begin
      instr_d = instr_q;
    end else if (!fifo_empty_s) begin
      instr_d = fifo_head_s;
    end else begin
      instr_d = BUBBLE;
    end

    if (accept_s && (issued_q != 16'hFFFF)) begin
      issued_d = issued_q + 16'd1;
    end else begin
      issued_d = issued_q;
    end

    done_d = (state_q == ST_HALT) && fifo_empty_s && !inflight_q && (instr_q == BUBBLE);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      pc_q       <= PC_RESET;
      inflight_q <= 1'b0;
      instr_q    <= BUBBLE;
      done_q     <= 1'b0;
      issued_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      instr_q    <= instr_d;
      done_q     <= done_d;
      issued_q   <= issued_d;
    end
  end

  instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (bus.imem_rdata),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .count_o     (fifo_count_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  instr_issue_queue_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_s),
    .pop_i  (pop_s),
    .full_i (fifo_full_s)
  );

  assign bus.imem_rd_en = req_s;
  assign bus.imem_addr  = pc_q;
  assign bus.instr      = instr_q;
  assign bus.done       = done_q;
  assign bus.issued_cnt = issued_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue with a 1-cycle-latency memory model.
module tb_instr_issue_queue;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] mem [64];

  localparam logic [31:0] W_ADDI = 32'h0010_0093;
  localparam logic [31:0] W_ADD  = 32'h0010_8133;
  localparam logic [31:0] W_LW   = 32'h0000_2183;
  localparam logic [31:0] W_SW   = 32'h0030_2223;
  localparam logic [31:0] W_UNK  = 32'h0000_007F;

  instr_issue_queue_if bus();

  instr_issue_queue #(.DEPTH(4), .PC_RESET(32'h0), .BUBBLE(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr[7:2]];
  end

  function automatic logic [31:0] add_w(input int k);
    return 32'h0000_0033 | (32'(k + 1) << 7);
  endfunction

  function automatic logic [31:0] addi_w(input int k);
    return 32'h0000_0013 | (32'(k + 1) << 20);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  // Leaves the bench one step into the first cycle after reset release (cycle 1).
  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    bus.fetch_en = 1'b1; bus.A_stall = 1'b0; bus.LS_stall = 1'b0;
    reset = 1'b0;
    tick();
    total++; if (bus.imem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", bus.imem_rd_en); end
    total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=00000000", bus.instr); end
    total++; if (bus.issued_cnt !== 16'd0) begin bad++; $display("FAIL reset_issued got=%0d exp=0", bus.issued_cnt); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    reset = 1'b1;
    #1;
    total++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_first_req rd=%b addr=%h exp rd=1 addr=0", bus.imem_rd_en, bus.imem_addr); end
  endtask

  task automatic test_basic();
    logic [31:0] seq [5];
    int over;
    seq[0] = W_ADDI; seq[1] = W_ADD; seq[2] = W_LW; seq[3] = W_SW; seq[4] = 32'h0;
    clear_mem();
    mem[0] = W_ADDI; mem[1] = W_ADD; mem[2] = W_LW; mem[3] = W_SW; mem[4] = 32'h0;
    bus.fetch_en = 1'b1; bus.A_stall = 1'b0; bus.LS_stall = 1'b0;
    over = 0;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      if (bus.imem_rd_en && bus.imem_addr > 32'h14) over++;
      if (c >= 4 && c <= 8) begin
        total++; if (bus.instr !== seq[c-4]) begin bad++; $display("FAIL basic_instr c=%0d got=%h exp=%h", c, bus.instr, seq[c-4]); end
      end
      if (c == 8) begin
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%b exp=0", bus.done); end
      end
      if (c == 9) begin
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", bus.done); end
        total++; if (bus.issued_cnt !== 16'd4) begin bad++; $display("FAIL basic_issued got=%0d exp=4", bus.issued_cnt); end
      end
      tick();
    end
    total++; if (over !== 0) begin bad++; $display("FAIL basic_extra_fetch got=%0d exp=0", over); end
  endtask

  task automatic test_stall_a();
    clear_mem();
    for (int k = 0; k < 12; k++) mem[k] = add_w(k);
    bus.fetch_en = 1'b1; bus.A_stall = 1'b0; bus.LS_stall = 1'b0;
    do_reset();
    tick(); tick(); tick();
    total++; if (bus.instr !== add_w(0)) begin bad++; $display("FAIL stall_a_first got=%h exp=%h", bus.instr, add_w(0)); end
    bus.A_stall = 1'b1;
    for (int c = 5; c <= 9; c++) begin
      tick();
      total++; if (bus.instr !== add_w(0)) begin bad++; $display("FAIL stall_a_hold c=%0d got=%h exp=%h", c, bus.instr, add_w(0)); end
      total++; if (bus.imem_rd_en !== (c == 5)) begin bad++; $display("FAIL stall_a_rd_en c=%0d got=%b exp=%b", c, bus.imem_rd_en, (c == 5)); end
    end
    bus.A_stall = 1'b0;
    tick();
    total++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h14) begin bad++; $display("FAIL stall_a_resume rd=%b addr=%h exp rd=1 addr=00000014", bus.imem_rd_en, bus.imem_addr); end
    total++; if (bus.instr !== add_w(1)) begin bad++; $display("FAIL stall_a_next got=%h exp=%h", bus.instr, add_w(1)); end
    tick();
    total++; if (bus.instr !== add_w(2)) begin bad++; $display("FAIL stall_a_next2 got=%h exp=%h", bus.instr, add_w(2)); end
  endtask

  task automatic test_stall_class();
    clear_mem();
    mem[0] = add_w(0); mem[1] = W_LW;
    bus.fetch_en = 1'b1; bus.A_stall = 1'b0; bus.LS_stall = 1'b1;
    do_reset();
    tick(); tick(); tick();
    total++; if (bus.instr !== add_w(0)) begin bad++; $display("FAIL class_add got=%h exp=%h", bus.instr, add_w(0)); end
    tick();
    total++; if (bus.instr !== W_LW) begin bad++; $display("FAIL class_lw got=%h exp=%h", bus.instr, W_LW); end
    total++; if (bus.issued_cnt !== 16'd1) begin bad++; $display("FAIL class_add_counted got=%0d exp=1", bus.issued_cnt); end
    tick();
    total++; if (bus.instr !== W_LW) begin bad++; $display("FAIL class_lw_hold1 got=%h exp=%h", bus.instr, W_LW); end
    tick();
    total++; if (bus.instr !== W_LW) begin bad++; $display("FAIL class_lw_hold2 got=%h exp=%h", bus.instr, W_LW); end
    total++; if (bus.issued_cnt !== 16'd1) begin bad++; $display("FAIL class_lw_not_counted got=%0d exp=1", bus.issued_cnt); end
    bus.LS_stall = 1'b0;
    tick();
    total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL class_drain got=%h exp=00000000", bus.instr); end
    total++; if (bus.issued_cnt !== 16'd2) begin bad++; $display("FAIL class_issued got=%0d exp=2", bus.issued_cnt); end
  endtask

  task automatic test_fetch_en();
    logic [31:0] got [$];
    clear_mem();
    for (int k = 0; k < 8; k++) mem[k] = addi_w(k);
    bus.fetch_en = 1'b1; bus.A_stall = 1'b0; bus.LS_stall = 1'b0;
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      if (c == 3) bus.fetch_en = 1'b0;
      if (c == 6) bus.fetch_en = 1'b1;
      #1;
      if (c >= 3 && c <= 5) begin
        total++; if (bus.imem_rd_en !== 1'b0) begin bad++; $display("FAIL fetch_en_off c=%0d got=%b exp=0", c, bus.imem_rd_en); end
      end
      if (c == 6) begin
        total++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h8) begin bad++; $display("FAIL fetch_en_resume rd=%b addr=%h exp rd=1 addr=00000008", bus.imem_rd_en, bus.imem_addr); end
      end
      if (bus.instr !== 32'h0) got.push_back(bus.instr);
      tick();
    end
    total++; if (got.size() !== 8) begin bad++; $display("FAIL fetch_en_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      total++; if (got[i] !== addi_w(i)) begin bad++; $display("FAIL fetch_en_order i=%0d got=%h exp=%h", i, got[i], addi_w(i)); end
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL fetch_en_done got=%b exp=1", bus.done); end
  endtask

  task automatic test_mid_reset();
    clear_mem();
    for (int k = 0; k < 12; k++) mem[k] = add_w(k);
    bus.fetch_en = 1'b1; bus.A_stall = 1'b0; bus.LS_stall = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick();
    bus.A_stall = 1'b1;
    tick(); tick();
    total++; if (bus.issued_cnt !== 16'd1) begin bad++; $display("FAIL mid_pre_issued got=%0d exp=1", bus.issued_cnt); end
    total++; if (bus.instr !== add_w(1)) begin bad++; $display("FAIL mid_pre_instr got=%h exp=%h", bus.instr, add_w(1)); end
    do_reset();
    bus.A_stall = 1'b0;
    total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL mid_instr got=%h exp=00000000", bus.instr); end
    total++; if (bus.issued_cnt !== 16'd0) begin bad++; $display("FAIL mid_issued got=%0d exp=0", bus.issued_cnt); end
    total++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL mid_req rd=%b addr=%h exp rd=1 addr=00000000", bus.imem_rd_en, bus.imem_addr); end
    tick(); tick(); tick();
    total++; if (bus.instr !== add_w(0)) begin bad++; $display("FAIL mid_restart0 got=%h exp=%h", bus.instr, add_w(0)); end
    tick();
    total++; if (bus.instr !== add_w(1)) begin bad++; $display("FAIL mid_restart1 got=%h exp=%h", bus.instr, add_w(1)); end
  endtask

  task automatic test_unknown_opcode();
    clear_mem();
    mem[0] = W_UNK; mem[1] = add_w(0);
    bus.fetch_en = 1'b1; bus.A_stall = 1'b1; bus.LS_stall = 1'b1;
    do_reset();
    tick(); tick(); tick();
    total++; if (bus.instr !== W_UNK) begin bad++; $display("FAIL unk_present got=%h exp=%h", bus.instr, W_UNK); end
    tick();
    total++; if (bus.instr !== add_w(0)) begin bad++; $display("FAIL unk_consumed got=%h exp=%h", bus.instr, add_w(0)); end
    tick();
    total++; if (bus.instr !== add_w(0)) begin bad++; $display("FAIL unk_add_held got=%h exp=%h", bus.instr, add_w(0)); end
    total++; if (bus.issued_cnt !== 16'd0) begin bad++; $display("FAIL unk_not_counted got=%0d exp=0", bus.issued_cnt); end
    bus.A_stall = 1'b0; bus.LS_stall = 1'b0;
    tick();
    total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL unk_drain got=%h exp=00000000", bus.instr); end
    total++; if (bus.issued_cnt !== 16'd1) begin bad++; $display("FAIL unk_issued got=%0d exp=1", bus.issued_cnt); end
  endtask

  initial begin
    bus.fetch_en = 1'b1;
    bus.A_stall  = 1'b0;
    bus.LS_stall = 1'b0;
    test_reset();
    test_basic();
    test_stall_a();
    test_stall_class();
    test_fetch_en();
    test_mid_reset();
    test_unknown_opcode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
